// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver.
// The serial line is synchronized, the start bit is qualified by a 2-of-3 majority,
// and 8 data bits are collected LSB first.
// An optional parity bit and the stop bit follow. Each frame ends in exactly one
// one-cycle strobe:
//   - data_valid when the frame is good,
//   - par_err on a parity mismatch,
//   - stp_err when the stop bit is sampled low (this one wins over par_err).
// The FSM state is kept in state_q so checkers can bind to it directly.
module uart_rx_frame #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SMP_0    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP_1    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SMP_2    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_meta_d;
    logic                  rx_s_q, rx_s_d;
    logic [CW-1:0]         edge_cnt_q, edge_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [1:0]            samp_q, samp_d;
    logic                  maj_q, maj_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_l_q, par_en_l_d;
    logic                  par_typ_l_q, par_typ_l_d;
    logic                  par_mis_q, par_mis_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic cnt_last;
    logic maj_now;
    logic par_exp;

    assign cnt_last = (edge_cnt_q == CNT_LAST);
    // Two early samples are held in samp_q; the third is the live synchronized line.
    assign maj_now  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign par_exp  = par_typ_l_q ? ~^shift_q : ^shift_q;

    // Next-state, counters, sampling and strobe generation.
    always_comb begin
        state_d      = state_q;
        rx_meta_d    = rx_in;
        rx_s_d       = rx_meta_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        maj_d        = maj_q;
        shift_d      = shift_q;
        par_en_l_d   = par_en_l_q;
        par_typ_l_d  = par_typ_l_q;
        par_mis_d    = par_mis_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = cnt_last ? '0 : edge_cnt_q + 1'b1;
            if (edge_cnt_q == SMP_0) samp_d[0] = rx_s_q;
            if (edge_cnt_q == SMP_1) samp_d[1] = rx_s_q;
            if (edge_cnt_q == SMP_2) maj_d     = maj_now;
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_s_q) begin
                    state_d     = START;
                    par_en_l_d  = par_en;
                    par_typ_l_d = par_typ;
                    par_mis_d   = 1'b0;
                end
            end
            START: begin
                if (cnt_last) begin
                    // A start bit that reads high at mid-bit was a glitch.
                    state_d   = maj_q ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    shift_d[bit_cnt_q] = maj_q;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_l_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (cnt_last) begin
                    par_mis_d = maj_q ^ par_exp;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    if (!maj_q) begin
                        stp_err_d = 1'b1;
                    end else if (par_mis_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                    // The frame ends here, which is the same cycle IDLE would test the line.
                    // If the next start bit is already low, take it now so no cycle is lost.
                    if (!rx_s_q) begin
                        state_d     = START;
                        par_en_l_d  = par_en;
                        par_typ_l_d = par_typ;
                        par_mis_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; asynchronous reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= 2'b11;
            maj_q        <= 1'b1;
            shift_q      <= '0;
            par_en_l_q   <= 1'b0;
            par_typ_l_q  <= 1'b0;
            par_mis_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            maj_q        <= maj_d;
            shift_q      <= shift_d;
            par_en_l_q   <= par_en_l_d;
            par_typ_l_q  <= par_typ_l_d;
            par_mis_q    <= par_mis_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame at OVERSAMPLE=8.
// A negedge monitor records every strobe into a queue. Each record holds the strobe
// kind, the p_data value at that moment, and the cycle number. Expected outcomes
// come from a frame-level model (popcount parity, priority of stop over parity
// errors, and a (10+par_en)*OS frame length).
module tb_uart_rx_frame;
  localparam int OS = 8;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_PAR   = 2'd1;
  localparam logic [1:0] K_STP   = 2'd2;

  logic       clk = 1'b0;
  logic       rest = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_frame #(.OVERSAMPLE(OS), .DATA_WIDTH(8)) dut (
    .clk(clk), .rest(rest), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  logic [7:0] last_good = 8'h00;

  // observed strobes: {kind, p_data} plus cycle stamp
  logic [9:0] ev_q[$];
  int         ev_cyc_q[$];
  // scoreboard expectations
  logic [9:0] exp_q[$];
  int         exp_cyc_q[$];

  always @(negedge clk) begin
    if (rest) begin
      if (data_valid) begin ev_q.push_back({K_VALID, p_data}); ev_cyc_q.push_back(cyc); end
      if (par_err)    begin ev_q.push_back({K_PAR, p_data});   ev_cyc_q.push_back(cyc); end
      if (stp_err)    begin ev_q.push_back({K_STP, p_data});   ev_cyc_q.push_back(cyc); end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic model_par_bit(input logic [7:0] d, input logic odd);
    int ones;
    ones = $countones(d);
    return odd ? logic'((ones + 1) % 2) : logic'(ones % 2);
  endfunction

  function automatic logic [1:0] model_kind(input logic [7:0] d, input logic pe, input logic pt,
                                            input logic pb, input logic sb);
    if (sb == 1'b0) return K_STP;
    if (pe && (pb != model_par_bit(d, pt))) return K_PAR;
    return K_VALID;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  // Assumes the caller is aligned #1 after a posedge; fall is the first cycle
  // whose edge can see the start bit.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic sb,
                            input bit scr, output int fall);
    fall = cyc + 1;
    drive_bit(1'b0);
    if (scr) begin
      par_en  = 1'($urandom);
      par_typ = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pe) drive_bit(pb);
    drive_bit(sb);
  endtask

  task automatic wait_events(input int n, input int budget);
    int k;
    k = 0;
    while (ev_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    ev_q.delete();
    ev_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rest = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (p_data !== 8'h00) $display("FAIL reset_p_data: got %h expected 00", p_data); else passes++;
    checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b expected 0", data_valid); else passes++;
    checks++; if (par_err !== 1'b0) $display("FAIL reset_par_err: got %b expected 0", par_err); else passes++;
    checks++; if (stp_err !== 1'b0) $display("FAIL reset_stp_err: got %b expected 0", stp_err); else passes++;
    rest = 1'b1;
    clear_events();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (ev_q.size() !== 0) $display("FAIL reset_idle_quiet: got %0d strobes expected 0", ev_q.size()); else passes++;
    last_good = 8'h00;
  endtask

  task automatic test_good_frame();
    int fall;
    logic [9:0] got;
    int gc;
    clear_events();
    par_en = 1'b1; par_typ = 1'b0;
    align();
    send_frame(8'hA5, 1'b1, model_par_bit(8'hA5, 1'b0), 1'b1, 1'b0, fall);
    rx_in = 1'b1;
    wait_events(1, 200);
    got = (ev_q.size() > 0) ? ev_q[0] : 10'h3ff;
    gc  = (ev_cyc_q.size() > 0) ? ev_cyc_q[0] : -1;
    checks++; if (ev_q.size() !== 1) $display("FAIL good_count: got %0d expected 1", ev_q.size()); else passes++;
    checks++; if (got !== {K_VALID, 8'hA5}) $display("FAIL good_event: got %h expected %h", got, {K_VALID, 8'hA5}); else passes++;
    checks++; if (gc !== fall + 2 + 11 * OS) $display("FAIL good_latency: got %0d expected %0d", gc - fall, 2 + 11 * OS); else passes++;
    checks++; if (p_data !== 8'hA5) $display("FAIL good_p_data: got %h expected a5", p_data); else passes++;
    last_good = 8'hA5;
  endtask

  task automatic test_parity_error();
    int fall;
    logic [9:0] got;
    clear_events();
    par_en = 1'b1; par_typ = 1'b1;
    align();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, fall);
    rx_in = 1'b1;
    wait_events(1, 200);
    got = (ev_q.size() > 0) ? ev_q[0] : 10'h3ff;
    checks++; if (ev_q.size() !== 1) $display("FAIL parity_count: got %0d expected 1", ev_q.size()); else passes++;
    checks++; if (got !== {K_PAR, last_good}) $display("FAIL parity_event: got %h expected %h", got, {K_PAR, last_good}); else passes++;
    checks++; if (p_data !== last_good) $display("FAIL parity_p_data_kept: got %h expected %h", p_data, last_good); else passes++;
  endtask

  task automatic test_stop_error();
    int fall;
    logic [9:0] got;
    int gc;
    clear_events();
    par_en = 1'b0; par_typ = 1'b0;
    align();
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, fall);
    rx_in = 1'b1;
    wait_events(1, 200);
    got = (ev_q.size() > 0) ? ev_q[0] : 10'h3ff;
    gc  = (ev_cyc_q.size() > 0) ? ev_cyc_q[0] : -1;
    checks++; if (ev_q.size() !== 1) $display("FAIL stop_count: got %0d expected 1", ev_q.size()); else passes++;
    checks++; if (got !== {K_STP, last_good}) $display("FAIL stop_event: got %h expected %h", got, {K_STP, last_good}); else passes++;
    checks++; if (gc !== fall + 2 + 10 * OS) $display("FAIL stop_latency: got %0d expected %0d", gc - fall, 2 + 10 * OS); else passes++;
  endtask

  task automatic test_glitch();
    int fall;
    logic [9:0] got;
    int gc;
    clear_events();
    par_en = 1'b0;
    align();
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (OS + 2 + 4) @(posedge clk);
    #1;
    checks++; if (ev_q.size() !== 0) $display("FAIL glitch_quiet: got %0d strobes expected 0", ev_q.size()); else passes++;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, fall);
    rx_in = 1'b1;
    wait_events(1, 200);
    got = (ev_q.size() > 0) ? ev_q[0] : 10'h3ff;
    gc  = (ev_cyc_q.size() > 0) ? ev_cyc_q[0] : -1;
    checks++; if (ev_q.size() !== 1) $display("FAIL glitch_next_count: got %0d expected 1", ev_q.size()); else passes++;
    checks++; if (got !== {K_VALID, 8'h5A}) $display("FAIL glitch_next_event: got %h expected %h", got, {K_VALID, 8'h5A}); else passes++;
    checks++; if (gc !== fall + 2 + 10 * OS) $display("FAIL glitch_next_latency: got %0d expected %0d", gc - fall, 2 + 10 * OS); else passes++;
    last_good = 8'h5A;
  endtask

  task automatic test_back_to_back();
    int f1, f2;
    logic [9:0] g0, g1;
    int c0, c1;
    clear_events();
    par_en = 1'b0;
    align();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, f1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, f2);
    rx_in = 1'b1;
    wait_events(2, 300);
    g0 = (ev_q.size() > 0) ? ev_q[0] : 10'h3ff;
    g1 = (ev_q.size() > 1) ? ev_q[1] : 10'h3ff;
    c0 = (ev_cyc_q.size() > 0) ? ev_cyc_q[0] : -1;
    c1 = (ev_cyc_q.size() > 1) ? ev_cyc_q[1] : -1000;
    checks++; if (ev_q.size() !== 2) $display("FAIL b2b_count: got %0d expected 2", ev_q.size()); else passes++;
    checks++; if (g0 !== {K_VALID, 8'hFF}) $display("FAIL b2b_first: got %h expected %h", g0, {K_VALID, 8'hFF}); else passes++;
    checks++; if (g1 !== {K_VALID, 8'h00}) $display("FAIL b2b_second: got %h expected %h", g1, {K_VALID, 8'h00}); else passes++;
    checks++; if (c1 - c0 !== 10 * OS) $display("FAIL b2b_spacing: got %0d expected %0d", c1 - c0, 10 * OS); else passes++;
    checks++; if (c0 !== f1 + 2 + 10 * OS) $display("FAIL b2b_latency: got %0d expected %0d", c0 - f1, 2 + 10 * OS); else passes++;
    last_good = 8'h00;
  endtask

  task automatic test_break();
    int fall;
    logic [9:0] got;
    int gc;
    clear_events();
    par_en = 1'b0;
    align();
    fall = cyc + 1;
    rx_in = 1'b0;
    repeat (3 * 10 * OS) @(posedge clk);
    #1;
    rx_in = 1'b1;
    wait_events(3, 200);
    checks++; if (ev_q.size() !== 3) $display("FAIL break_count: got %0d expected 3", ev_q.size()); else passes++;
    for (int i = 0; i < 3; i++) begin
      got = (i < ev_q.size()) ? ev_q[i] : 10'h3ff;
      gc  = (i < ev_cyc_q.size()) ? ev_cyc_q[i] : -1;
      checks++; if (got !== {K_STP, last_good}) $display("FAIL break_event%0d: got %h expected %h", i, got, {K_STP, last_good}); else passes++;
      checks++; if (gc !== fall + 2 + (i + 1) * 10 * OS) $display("FAIL break_time%0d: got %0d expected %0d", i, gc - fall, 2 + (i + 1) * 10 * OS); else passes++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int fall;
    logic [9:0] got;
    logic [7:0] d;
    clear_events();
    par_en = 1'b0;
    align();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, fall);
    rx_in = 1'b1;
    wait_events(1, 200);
    checks++; if (p_data !== 8'hC3) $display("FAIL rstmid_pre_p_data: got %h expected c3", p_data); else passes++;
    clear_events();
    d = 8'h77;
    align();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_in = d[4];
    repeat (OS / 2) @(posedge clk);
    #1;
    rest = 1'b0;
    #1;
    checks++; if (p_data !== 8'h00) $display("FAIL rstmid_p_data: got %h expected 00", p_data); else passes++;
    checks++; if ({data_valid, par_err, stp_err} !== 3'b000) $display("FAIL rstmid_strobes: got %b expected 000", {data_valid, par_err, stp_err}); else passes++;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rest = 1'b1;
    last_good = 8'h00;
    repeat (12 * OS) @(posedge clk);
    #1;
    checks++; if (ev_q.size() !== 0) $display("FAIL rstmid_no_strobe: got %0d strobes expected 0", ev_q.size()); else passes++;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, fall);
    rx_in = 1'b1;
    wait_events(1, 200);
    got = (ev_q.size() > 0) ? ev_q[0] : 10'h3ff;
    checks++; if (got !== {K_VALID, 8'h81}) $display("FAIL rstmid_next: got %h expected %h", got, {K_VALID, 8'h81}); else passes++;
    last_good = 8'h81;
  endtask

  // Random frames, random gaps (often none), random bad parity/stop, and
  // par_en/par_typ scrambled mid-frame to show they are only taken at frame start.
  task automatic test_random();
    int fall;
    int nfr;
    logic [7:0] d;
    logic pe, pt, pb, sb;
    logic [1:0] k;
    logic [9:0] got;
    int gc;
    int gap;
    nfr = 30;
    clear_events();
    exp_q.delete();
    exp_cyc_q.delete();
    align();
    for (int n = 0; n < nfr; n++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      pb = model_par_bit(d, pt);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      sb = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      par_en = pe;
      par_typ = pt;
      send_frame(d, pe, pb, sb, 1'b1, fall);
      k = model_kind(d, pe, pt, pb, sb);
      if (k == K_VALID) last_good = d;
      exp_q.push_back({k, last_good});
      exp_cyc_q.push_back(fall + 2 + (10 + int'(pe)) * OS);
      rx_in = 1'b1;
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 20);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
    rx_in = 1'b1;
    wait_events(nfr, 400);
    checks++; if (ev_q.size() !== nfr) $display("FAIL rand_count: got %0d expected %0d", ev_q.size(), nfr); else passes++;
    for (int i = 0; i < nfr; i++) begin
      got = (i < ev_q.size()) ? ev_q[i] : 10'h3ff;
      gc  = (i < ev_cyc_q.size()) ? ev_cyc_q[i] : -1;
      checks++; if (got !== exp_q[i]) $display("FAIL rand_event%0d: got %h expected %h", i, got, exp_q[i]); else passes++;
      checks++; if (gc !== exp_cyc_q[i]) $display("FAIL rand_time%0d: got %0d expected %0d", i, gc, exp_cyc_q[i]); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receiver: the far end of the team's UART_TX serializer and parity path. It oversamples the serial line, detects and validates the start bit, and deserializes 8 data bits LSB-first. It then checks the optional parity bit and the stop bit, and presents the byte with a one-cycle valid strobe or a one-cycle error strobe.

Parameters:
OVERSAMPLE, 8, clk cycles per bit; legal values 8, 16, 32 only.
DATA_WIDTH, 8, data bits per frame; fixed at 8 for this release.

Ports:
clk  input  1  system clock; all state advances on posedge.
rest  input  1  asynchronous active-low reset.
rx_in  input  1  serial line, idle high, asynchronous to clk.
par_en  input  1  1 = frame carries a parity bit after the data bits.
par_typ  input  1  1 = odd parity (expected bit = ~^data); 0 = even (expected bit = ^data).
p_data  output  8  last good received byte.
data_valid  output  1  one-cycle strobe: p_data updated with a good frame.
par_err  output  1  one-cycle strobe: parity mismatch.
stp_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rest).
- Reset state:
  - p_data = 8'h00; data_valid, par_err and stp_err = 0.
  - FSM = IDLE; all counters = 0.
  - Both synchronizer flops = 1 (line idle).
  - Reset asserted mid-frame aborts the frame immediately. No strobe is issued.
- Input path: rx_in passes through a 2-flop synchronizer (rx_s). All logic below uses rx_s only.
- Counters:
  - edge_cnt runs 0..OVERSAMPLE-1 and wraps to 0.
  - bit_cnt runs 0..7.
- Sampling:
  - Three samples per bit, taken at edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the 2-of-3 majority, registered at edge_cnt = OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s==0 → START, edge_cnt=0. par_en and par_typ are latched here and held for the whole frame.
  - START: when edge_cnt reaches OVERSAMPLE-1:
    - majority 0 → DATA.
    - majority 1 → glitch; return to IDLE silently with no strobes.
  - DATA: the majority is shifted into bit position bit_cnt (LSB first). At edge_cnt=OVERSAMPLE-1, bit_cnt increments. After bit 7 → PARITY if par_en latched, else STOP.
  - PARITY: the majority is compared against the expected parity of the 8 received bits; the mismatch flag is held. At edge_cnt=OVERSAMPLE-1 → STOP.
  - STOP: at edge_cnt=OVERSAMPLE-1 → IDLE, and exactly one outcome is registered for the following cycle:
    - stop majority 0 → stp_err=1 (stp_err takes priority; par_err is not also raised).
    - else parity mismatch → par_err=1.
    - else data_valid=1 and p_data is loaded.
  - p_data changes only on a good frame. An errored frame leaves it unchanged.
- Strobes: each strobe is high for exactly one clk.
- Timing:
  - Frame length is (10+par_en)*OVERSAMPLE clk.
  - The strobe appears 2 (synchronizer) + (10+par_en)*OVERSAMPLE clk after the rx_in falling edge.
  - IDLE is re-entered in the same cycle the strobe is registered, so a back-to-back start bit is detected with no lost cycles.
- Other boundary rules:
  - A break (rx_in held low) yields stp_err once per frame time, then repeated frames while the line stays low.
  - par_en and par_typ changes mid-frame are ignored until the next IDLE.

Test Plan:
1. OVERSAMPLE=8, par_en=1, par_typ=0, send 0xA5 with parity bit 0 and stop bit 1 → p_data=8'hA5 and data_valid=1 for 1 cycle, exactly 2+88 clk after the falling edge; par_err=0, stp_err=0.
2. par_typ=1 (odd), send 0x3C with parity bit 0 (correct bit is 1) → par_err=1 for 1 cycle; data_valid=0; p_data keeps its previous value.
3. par_en=0, send 0x01 with stop bit driven 0 → stp_err=1 for 1 cycle at 2+80 clk; data_valid=0.
4. rx_in pulsed low for 2 clk then held high → no strobes; FSM back in IDLE within OVERSAMPLE+2 clk; a following valid 0x5A frame is received correctly.
5. Two frames 0xFF then 0x00 sent back-to-back with no idle gap, par_en=0 → two data_valid pulses exactly 80 clk apart, carrying 8'hFF then 8'h00.
6. rest pulsed low during bit 4 of a frame → all outputs go to 0 immediately with no strobe; the next complete frame 0x81 → data_valid with p_data=8'h81.
